pwm_duty_meter: RTL and testbench

//  Multi-channel PWM measurement block; generalises the fixed 3-channel RGB high-time counter.
//  Per channel: counts high cycles and rising edges over a programmable window of clk cycles.
//  At window end, all results are snapshotted into stable output registers and strobed once.

---
 rtl/pwm_meas_pkg.sv | 20 ++
 rtl/pwm_duty_meter_if.sv | 30 +++
 rtl/pwm_chan_acc.sv | 58 +++++
 rtl/pwm_duty_meter.sv | 118 +++++++++++
 tb/tb_pwm_duty_meter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_meas_pkg.sv
// Shared types and helpers for the multi-channel PWM duty meter.
// State encoding, default window length and packed-bus slicing.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  localparam logic [31:0] WIN_DEFAULT_C = 32'h0090_0000;

  function automatic int unsigned ch_lsb(
    input int unsigned ch,
    input int unsigned w
  );
    return ch * w;
  endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Control/result bundle between the PWM meter and its host.
// master = host side, slave = meter side.
interface pwm_duty_meter_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32
) ();

  logic [NUM_CH-1:0]       pwm_in;
  logic [CNT_W-1:0]        win_len;
  logic                    mode;
  logic                    start;
  logic                    busy;
  logic                    meas_valid;
  logic [NUM_CH*CNT_W-1:0] high_cnt;
  logic [NUM_CH*CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0]        total_cnt;

  modport master (
    output pwm_in, win_len, mode, start,
    input  busy, meas_valid, high_cnt,
    input  edge_cnt, total_cnt
  );

  modport slave (
    input  pwm_in, win_len, mode, start,
    output busy, meas_valid, high_cnt,
    output edge_cnt, total_cnt
  );

endinterface

// File: rtl/pwm_chan_acc.sv
// One PWM channel: input synchroniser, rising-edge detect and
// high-cycle / edge accumulators with clear and enable.
module pwm_chan_acc #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] acc_hi,
  output logic [CNT_W-1:0] acc_ed
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [CNT_W-1:0]       ed_q, ed_d;
  logic                   s;
  logic                   rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

  // prev tracks s in every state so edges across window joins are kept
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    prev_d = s;
    hi_d   = hi_q;
    ed_d   = ed_q;
    if (clr) begin
      hi_d = '0;
      ed_d = '0;
    end else if (en) begin
      hi_d = hi_q + CNT_W'(s);
      ed_d = ed_q + CNT_W'(rise);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      hi_q   <= '0;
      ed_q   <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      hi_q   <= hi_d;
      ed_q   <= ed_d;
    end
  end

  assign acc_hi = hi_q;
  assign acc_ed = ed_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Multi-channel PWM duty/edge meter: window FSM, cycle counter
// and snapshot registers around per-channel accumulators.
module pwm_duty_meter
  import pwm_meas_pkg::*;
#(
  parameter int               NUM_CH      = 3,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] WIN_DEFAULT = CNT_W'(WIN_DEFAULT_C),
  parameter int               SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  pwm_duty_meter_if.slave bus
);

  localparam int BW = NUM_CH * CNT_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [BW-1:0]    hi_q, hi_d;
  logic [BW-1:0]    ed_q, ed_d;
  logic             busy_q, busy_d;
  logic             mv_q, mv_d;
  logic [BW-1:0]    acc_hi;
  logic [BW-1:0]    acc_ed;
  logic [CNT_W-1:0] win_sel;
  logic             run;

  assign win_sel = (bus.win_len == '0) ? WIN_DEFAULT : bus.win_len;
  assign run     = (state_q == S_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_chan_acc #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (bus.pwm_in[i]),
      .clr    (!run),
      .en     (run),
      .acc_hi (acc_hi[ch_lsb(i, CNT_W) +: CNT_W]),
      .acc_ed (acc_ed[ch_lsb(i, CNT_W) +: CNT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    tc_d    = tc_q;
    tot_d   = tot_q;
    hi_d    = hi_q;
    ed_d    = ed_q;
    mv_d    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!bus.mode || bus.start) begin
          state_d = S_RUN;
          win_d   = win_sel;
          tc_d    = '0;
        end
      end
      (state_q == S_RUN): begin
        tc_d = tc_q + CNT_W'(1);
        if (tc_q == win_q - CNT_W'(1)) begin
          state_d = S_LATCH;
        end
      end
      // sample of this cycle is dropped; accumulators clear here
      (state_q == S_LATCH): begin
        hi_d  = acc_hi;
        ed_d  = acc_ed;
        tot_d = win_q;
        mv_d  = 1'b1;
        if (!bus.mode) begin
          state_d = S_RUN;
          win_d   = win_sel;
          tc_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      tc_q    <= '0;
      tot_q   <= '0;
      hi_q    <= '0;
      ed_q    <= '0;
      busy_q  <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      tc_q    <= tc_d;
      tot_q   <= tot_d;
      hi_q    <= hi_d;
      ed_q    <= ed_d;
      busy_q  <= busy_d;
      mv_q    <= mv_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.meas_valid = mv_q;
  assign bus.high_cnt   = hi_q;
  assign bus.edge_cnt   = ed_q;
  assign bus.total_cnt  = tot_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: window-level reference model with a
// per-cycle compare, directed scenarios and randomized stimulus.
module tb_pwm_duty_meter;

  localparam int NCH  = 3;
  localparam int CW   = 32;
  localparam int SS   = 2;
  localparam int WD   = 4096;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_meter_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  pwm_duty_meter #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .WIN_DEFAULT (32'd4096),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: input history per clock edge, windows as
  // (first sampling edge, length), results summed from history.
  bit [NCH-1:0] hist [MAXC];
  int           cyc = -1;
  bit           m_busy = 1'b0;
  int           m_first, m_w;
  logic [31:0]  e_hi [NCH];
  logic [31:0]  e_ed [NCH];
  logic [31:0]  e_tot;
  logic         e_busy, e_mv;
  bit           chk_on = 1'b0;

  function automatic bit [NCH-1:0] xs(input int k);
    if (k < 0 || k >= MAXC) return '0;
    return hist[k];
  endfunction

  task automatic model_clear();
    m_busy = 1'b0;
    e_busy = 1'b0;
    e_mv   = 1'b0;
    e_tot  = '0;
    for (int i = 0; i < NCH; i++) begin
      e_hi[i] = '0;
      e_ed[i] = '0;
    end
  endtask

  task automatic model_latch();
    bit [NCH-1:0] s, p;
    for (int i = 0; i < NCH; i++) begin
      e_hi[i] = '0;
      e_ed[i] = '0;
    end
    for (int e = m_first; e < m_first + m_w; e++) begin
      s = xs(e - SS);
      p = xs(e - SS - 1);
      for (int i = 0; i < NCH; i++) begin
        e_hi[i] += 32'(s[i]);
        e_ed[i] += 32'(s[i] & ~p[i]);
      end
    end
    e_tot = 32'(m_w);
  endtask

  function automatic int sel_win(input logic [CW-1:0] w);
    return (w == '0) ? WD : int'(w);
  endfunction

  initial model_clear();

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (cyc < MAXC) hist[cyc] = '0;
      model_clear();
    end else begin
      if (cyc < MAXC) hist[cyc] = bus.pwm_in;
      e_mv = 1'b0;
      if (!m_busy) begin
        if (!bus.mode || bus.start) begin
          m_busy  = 1'b1;
          m_first = cyc + 1;
          m_w     = sel_win(bus.win_len);
        end
      end else if (cyc == m_first + m_w) begin
        model_latch();
        e_mv = 1'b1;
        if (!bus.mode) begin
          m_first = cyc + 1;
          m_w     = sel_win(bus.win_len);
        end else begin
          m_busy = 1'b0;
        end
      end
      e_busy = m_busy;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("meas_valid", 32'(bus.meas_valid), 32'(e_mv));
      chk("total_cnt", bus.total_cnt, e_tot);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("high_cnt%0d", i), bus.high_cnt[i*CW +: CW], e_hi[i]);
        chk($sformatf("edge_cnt%0d", i), bus.edge_cnt[i*CW +: CW], e_ed[i]);
      end
    end
  end

  // Stimulus: gen 0 = ch0 high, ch1 low, ch2 toggling;
  // gen 1 = ch0 period-10 PWM with 3 high; gen 2 = random + glitches.
  int gen = 0;
  bit tog = 1'b0;
  int ph  = 0;

  task automatic step(input int n);
    logic [NCH-1:0] m;
    repeat (n) begin
      @(negedge clk);
      case (gen)
        0: begin
          tog        = ~tog;
          bus.pwm_in = {tog, 1'b0, 1'b1};
        end
        1: begin
          ph            = (ph + 1) % 10;
          bus.pwm_in    = '0;
          bus.pwm_in[0] = (ph < 3);
        end
        default: begin
          bus.pwm_in = NCH'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            m = NCH'($urandom_range(1, 7));
            #1 bus.pwm_in = bus.pwm_in ^ m;
            #2 bus.pwm_in = bus.pwm_in ^ m;
          end
        end
      endcase
    end
  endtask

  task automatic wait_mv(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.meas_valid && n < budget);
    chk("meas_valid_seen", 32'(bus.meas_valid), 32'd1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] hi(input int ch);
    return bus.high_cnt[ch*CW +: CW];
  endfunction

  function automatic logic [31:0] ed(input int ch);
    return bus.edge_cnt[ch*CW +: CW];
  endfunction

  int n;
  int cnt;

  initial begin
    bus.pwm_in  = '0;
    bus.win_len = 32'd100;
    bus.mode    = 1'b1;
    bus.start   = 1'b0;
    step(3);
    chk_on = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mv", 32'(bus.meas_valid), 32'd0);
    chk("rst_total", bus.total_cnt, 32'd0);
    chk("rst_high0", hi(0), 32'd0);
    rst = 1'b1;
    step(5);

    // continuous, 100-cycle windows
    bus.mode = 1'b0;
    wait_mv(300, n);
    wait_mv(200, n);
    chk("t1_gap", 32'(n), 32'd101);
    chk("t1_high0", hi(0), 32'd100);
    chk("t1_high1", hi(1), 32'd0);
    chk("t1_high2", hi(2), 32'd50);
    chk("t1_edge2", ed(2), 32'd50);
    chk("t1_total", bus.total_cnt, 32'd100);
    wait_mv(200, n);
    chk("t1_gap2", 32'(n), 32'd101);
    chk("t1_high0b", hi(0), 32'd100);

    // mid-window changes apply only from the next decision
    step(20);
    bus.win_len = 32'd40;
    bus.mode    = 1'b1;
    wait_mv(200, n);
    chk("t5_total", bus.total_cnt, 32'd100);
    chk("t5_high0", hi(0), 32'd100);
    step(2);
    chk("t5_idle", 32'(bus.busy), 32'd0);
    step(5);
    pulse_start();
    wait_mv(100, n);
    chk("t5_total40", bus.total_cnt, 32'd40);
    chk("t5_high40", hi(0), 32'd40);

    // single-shot 1000 window, start while busy ignored
    gen = 1;
    bus.win_len = 32'd1000;
    step(30);
    pulse_start();
    step(100);
    pulse_start();
    wait_mv(1200, n);
    chk("t2_high0", hi(0), 32'd300);
    chk("t2_edge0", ed(0), 32'd100);
    chk("t2_total", bus.total_cnt, 32'd1000);
    chk("t2_high1", hi(1), 32'd0);
    step(2);
    chk("t2_busy", 32'(bus.busy), 32'd0);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (bus.meas_valid) cnt++;
    end
    chk("t2_no_more", 32'(cnt), 32'd0);

    // default window, then single-sample windows
    gen = 0;
    bus.win_len = '0;
    step(5);
    pulse_start();
    wait_mv(4300, n);
    chk("t3_total_def", bus.total_cnt, 32'd4096);
    chk("t3_high0_def", hi(0), 32'd4096);
    chk("t3_high2_def", hi(2), 32'd2048);
    bus.win_len = 32'd1;
    bus.mode    = 1'b0;
    wait_mv(20, n);
    wait_mv(10, n);
    chk("t3_gap1", 32'(n), 32'd2);
    chk("t3_high1win", hi(0), 32'd1);
    chk("t3_total1", bus.total_cnt, 32'd1);
    bus.mode = 1'b1;
    step(5);

    // reset in the middle of a window
    bus.win_len = 32'd100;
    bus.mode    = 1'b0;
    wait_mv(300, n);
    step(50);
    #2 rst = 1'b0;
    #1;
    chk("t4_high0", hi(0), 32'd0);
    chk("t4_total", bus.total_cnt, 32'd0);
    chk("t4_mv", 32'(bus.meas_valid), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    bus.mode = 1'b1;
    step(3);
    rst = 1'b1;
    step(5);
    bus.mode = 1'b0;
    wait_mv(300, n);
    chk("t4_fresh_high0", hi(0), 32'd100);
    chk("t4_fresh_edge2", ed(2), 32'd50);
    chk("t4_fresh_total", bus.total_cnt, 32'd100);

    // random inputs, glitches and control against the model
    gen = 2;
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) bus.mode = ~bus.mode;
      bus.start   = ($urandom_range(0, 7) == 0);
      bus.win_len = CW'($urandom_range(1, 24));
      if (k == 1500) begin
        #2 rst = 1'b0;
        step(2);
        rst = 1'b1;
      end
      step(1);
      if (bus.meas_valid) cnt++;
    end
    chk("t6_windows", 32'(cnt > 0), 32'd1);
    bus.mode  = 1'b1;
    bus.start = 1'b0;
    step(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
